// File: rtl/sram_arbiter.sv
`timescale 1ns/1ps
// Two-master arbiter for one sram-like slave port: captures one request at a
// time, replays it on the shared port and routes the response to its owner.
module sram_arbiter #(
    parameter int DATA_PRIO = 0
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic [31:0] m1_rdata,

    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata
);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_t;

    state_t      state, state_nxt;
    logic        grant;       // 0 = m0, 1 = m1
    logic        last_grant;
    logic        capture;
    logic        win;
    logic        req_wr;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_nxt  = state;
        capture    = 1'b0;
        win        = 1'b0;
        m0_addr_ok = 1'b0;
        m1_addr_ok = 1'b0;
        m0_data_ok = 1'b0;
        m1_data_ok = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    capture = 1'b1;
                    if (m0_req && m1_req)
                        win = (DATA_PRIO != 0) ? 1'b1 : ~last_grant;
                    else
                        win = m1_req;
                    m0_addr_ok = ~win;
                    m1_addr_ok = win;
                    state_nxt  = ADDR;
                end
            end
            ADDR: begin
                if (s_addr_ok)
                    state_nxt = WAIT;
            end
            WAIT: begin
                // s_data_ok is only honoured here; elsewhere it is ignored.
                if (s_data_ok) begin
                    m0_data_ok = ~grant;
                    m1_data_ok = grant;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            req_wr     <= 1'b0;
            req_size   <= 2'd0;
            req_addr   <= 32'd0;
            req_wdata  <= 32'd0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state <= state_nxt;
            if (capture) begin
                grant      <= win;
                last_grant <= win;
                req_wr     <= win ? m1_wr    : m0_wr;
                req_size   <= win ? m1_size  : m0_size;
                req_addr   <= win ? m1_addr  : m0_addr;
                req_wdata  <= win ? m1_wdata : m0_wdata;
            end
        end
    end

    // Slave-side outputs come only from registers: no s_* input to s_* output path.
    assign s_req    = (state == ADDR);
    assign s_wr     = req_wr;
    assign s_size   = req_size;
    assign s_addr   = req_addr;
    assign s_wdata  = req_wdata;

    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
// Bench for sram_arbiter: round-robin instance driven from a vector table and
// hand sequences with a response scoreboard, plus a fixed-priority instance.
module tb_sram_arbiter;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic        m0_req, m0_wr, m0_addr_ok, m0_data_ok;
    logic [1:0]  m0_size;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_wr, m1_addr_ok, m1_data_ok;
    logic [1:0]  m1_size;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        s_req, s_wr, s_addr_ok, s_data_ok;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata, s_rdata;

    logic        f_m0_req, f_m0_addr_ok, f_m0_data_ok;
    logic [31:0] f_m0_rdata;
    logic        f_m1_req, f_m1_addr_ok, f_m1_data_ok;
    logic [31:0] f_m1_rdata;
    logic        f_s_req, f_s_wr;
    logic [1:0]  f_s_size;
    logic [31:0] f_s_addr, f_s_wdata;
    logic        f_s_addr_ok, f_s_data_ok;
    logic [31:0] f_s_rdata;

    sram_arbiter #(.DATA_PRIO(0)) dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok),
        .m1_rdata(m1_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
        .s_rdata(s_rdata)
    );

    sram_arbiter #(.DATA_PRIO(1)) dut_fp (
        .clk(clk), .resetn(resetn),
        .m0_req(f_m0_req), .m0_wr(1'b0), .m0_size(2'd2), .m0_addr(32'h0000_1000),
        .m0_wdata(32'd0), .m0_addr_ok(f_m0_addr_ok), .m0_data_ok(f_m0_data_ok),
        .m0_rdata(f_m0_rdata),
        .m1_req(f_m1_req), .m1_wr(1'b0), .m1_size(2'd2), .m1_addr(32'h0000_2000),
        .m1_wdata(32'd0), .m1_addr_ok(f_m1_addr_ok), .m1_data_ok(f_m1_data_ok),
        .m1_rdata(f_m1_rdata),
        .s_req(f_s_req), .s_wr(f_s_wr), .s_size(f_s_size), .s_addr(f_s_addr),
        .s_wdata(f_s_wdata), .s_addr_ok(f_s_addr_ok), .s_data_ok(f_s_data_ok),
        .s_rdata(f_s_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic        r0, r1;
        logic        wr0, wr1;
        logic [1:0]  sz0, sz1;
        logic [31:0] a0, a1, wd0, wd1;
        int          adly, ddly;
        logic [31:0] rdata;
        logic        win;
    } vec_t;

    function automatic vec_t mk(logic r0, logic r1,
                                logic wr0, logic [1:0] sz0, logic [31:0] a0, logic [31:0] wd0,
                                logic wr1, logic [1:0] sz1, logic [31:0] a1, logic [31:0] wd1,
                                int adly, int ddly, logic [31:0] rdata, logic win);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.wr0 = wr0; v.wr1 = wr1; v.sz0 = sz0; v.sz1 = sz1;
        v.a0 = a0; v.a1 = a1; v.wd0 = wd0; v.wd1 = wd1;
        v.adly = adly; v.ddly = ddly; v.rdata = rdata; v.win = win;
        return v;
    endfunction

    // Scoreboard of expected responses, pushed when s_data_ok is driven in WAIT.
    typedef struct packed {
        logic        win;
        logic [31:0] rdata;
    } resp_t;
    resp_t sb[$];
    resp_t exp_resp;

    always @(negedge clk) begin
        if (m0_data_ok || m1_data_ok) begin
            if (sb.size() == 0) begin
                check("data_ok_unexpected", {m1_data_ok, m0_data_ok}, 2'b00);
            end else begin
                exp_resp = sb.pop_front();
                check("data_ok_route", {m1_data_ok, m0_data_ok}, exp_resp.win ? 2'b10 : 2'b01);
                check("rdata", exp_resp.win ? m1_rdata : m0_rdata, exp_resp.rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [66:0] fields_of(vec_t v);
        return v.win ? {v.wr1, v.sz1, v.a1, v.wd1} : {v.wr0, v.sz0, v.a0, v.wd0};
    endfunction

    task automatic capture(input vec_t v);
        m0_req = v.r0; m0_wr = v.wr0; m0_size = v.sz0; m0_addr = v.a0; m0_wdata = v.wd0;
        m1_req = v.r1; m1_wr = v.wr1; m1_size = v.sz1; m1_addr = v.a1; m1_wdata = v.wd1;
        s_addr_ok = 1'b0; s_data_ok = 1'b0;
        @(negedge clk);
        check("addr_ok", {m1_addr_ok, m0_addr_ok}, v.win ? 2'b10 : 2'b01);
        check("s_req_idle", s_req, 1'b0);
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    // Starts in ADDR; ends after the response, back in IDLE.
    task automatic finish(input logic win, input logic [66:0] fields,
                          input int adly, input int ddly, input logic [31:0] rd);
        for (int i = 0; i < adly; i++) begin
            @(negedge clk);
            check("s_req_stall", s_req, 1'b1);
            check("s_fields_stall", {s_wr, s_size, s_addr, s_wdata}, fields);
            check("data_ok_addr", {m1_data_ok, m0_data_ok}, 2'b00);
            tick();
        end
        s_addr_ok = 1'b1;
        @(negedge clk);
        check("s_req_accept", s_req, 1'b1);
        check("s_fields", {s_wr, s_size, s_addr, s_wdata}, fields);
        tick();
        s_addr_ok = 1'b0;
        for (int i = 0; i < ddly; i++) begin
            @(negedge clk);
            check("s_req_wait", s_req, 1'b0);
            check("data_ok_wait", {m1_data_ok, m0_data_ok}, 2'b00);
            tick();
        end
        s_data_ok = 1'b1;
        s_rdata   = rd;
        sb.push_back('{win: win, rdata: rd});
        @(negedge clk);
        check("s_req_resp", s_req, 1'b0);
        tick();
        s_data_ok = 1'b0;
        s_rdata   = $urandom;
    endtask

    vec_t vecs[8];
    vec_t hv;
    int   grants;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(1, 0, 0, 2'd2, 32'h1FC0_0000, 32'd0,         0, 2'd2, 32'h8000_0100, 32'd0,
                     0, 1, 32'hDEAD_BEEF, 1'b0);
        vecs[1] = mk(1, 1, 0, 2'd2, 32'h1FC0_0004, 32'd0,         0, 2'd2, 32'h8000_0200, 32'd0,
                     0, 0, 32'h1111_1111, 1'b1);
        vecs[2] = mk(1, 1, 0, 2'd2, 32'h1FC0_0008, 32'd0,         1, 2'd1, 32'h8000_0300, 32'h0000_BEEF,
                     1, 0, 32'h2222_2222, 1'b0);
        vecs[3] = mk(1, 1, 1, 2'd0, 32'h1FC0_000C, 32'h0000_00AA, 0, 2'd2, 32'h8000_0400, 32'd0,
                     0, 2, 32'h3333_3333, 1'b1);
        vecs[4] = mk(0, 1, 0, 2'd0, 32'd0,         32'd0,         1, 2'd2, 32'h0000_0010, 32'h1234_5678,
                     5, 1, 32'h4444_4444, 1'b1);
        vecs[5] = mk(1, 1, 0, 2'd2, 32'h1FC0_0010, 32'd0,         0, 2'd2, 32'h8000_0500, 32'd0,
                     2, 0, 32'h5555_5555, 1'b0);
        vecs[6] = mk(0, 1, 0, 2'd0, 32'd0,         32'd0,         0, 2'd0, 32'h8000_0601, 32'd0,
                     0, 3, 32'h6666_6666, 1'b1);
        vecs[7] = mk(1, 1, 1, 2'd1, 32'h1FC0_0012, 32'h0000_7777, 0, 2'd2, 32'h8000_0700, 32'd0,
                     1, 1, 32'h7777_7777, 1'b0);

        resetn = 1'b0;
        m0_req = 0; m0_wr = 0; m0_size = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_wr = 0; m1_size = 0; m1_addr = 0; m1_wdata = 0;
        s_addr_ok = 0; s_data_ok = 1'b1; s_rdata = 32'hFFFF_FFFF;
        f_m0_req = 0; f_m1_req = 0;
        f_s_addr_ok = 1'b1; f_s_data_ok = 1'b1; f_s_rdata = 32'h5A5A_5A5A;

        // Reset state, with a stray s_data_ok present.
        @(negedge clk);
        check("reset_s_req", s_req, 1'b0);
        check("reset_fields", {s_wr, s_size, s_addr, s_wdata}, 67'd0);
        check("reset_ok", {m1_addr_ok, m0_addr_ok, m1_data_ok, m0_data_ok}, 4'b0000);
        tick();
        s_data_ok = 1'b0;
        resetn    = 1'b1;

        for (int i = 0; i < 8; i++) begin
            capture(vecs[i]);
            finish(vecs[i].win, fields_of(vecs[i]), vecs[i].adly, vecs[i].ddly, vecs[i].rdata);
        end

        // Spurious s_data_ok in IDLE and ADDR; m0 blocked during m1's WAIT.
        s_data_ok = 1'b1;
        @(negedge clk);
        check("spurious_idle", {m1_data_ok, m0_data_ok}, 2'b00);
        tick();
        s_data_ok = 1'b0;
        m1_req = 1'b1; m1_wr = 1'b0; m1_size = 2'd2; m1_addr = 32'h2000_0000;
        @(negedge clk);
        check("blk_m1_addr_ok", {m1_addr_ok, m0_addr_ok}, 2'b10);
        tick();
        m1_req = 1'b0;
        s_addr_ok = 1'b1; s_data_ok = 1'b1;
        @(negedge clk);
        check("spurious_addr_sreq", s_req, 1'b1);
        check("spurious_addr", {m1_data_ok, m0_data_ok}, 2'b00);
        tick();
        s_addr_ok = 1'b0; s_data_ok = 1'b0;
        m0_req = 1'b1; m0_wr = 1'b1; m0_size = 2'd2; m0_addr = 32'h3000_0000; m0_wdata = 32'hA5A5_0001;
        @(negedge clk);
        check("dropped_same_cycle", {m1_data_ok, m0_data_ok}, 2'b00);
        check("blocked_wait", {m1_addr_ok, m0_addr_ok}, 2'b00);
        tick();
        s_data_ok = 1'b1; s_rdata = 32'hCAFE_F00D;
        sb.push_back('{win: 1'b1, rdata: 32'hCAFE_F00D});
        @(negedge clk);
        check("blocked_data_ok", {m1_addr_ok, m0_addr_ok}, 2'b00);
        tick();
        s_data_ok = 1'b0;
        @(negedge clk);
        check("blocked_granted", {m1_addr_ok, m0_addr_ok}, 2'b01);
        tick();
        m0_req = 1'b0;
        finish(1'b0, {1'b1, 2'd2, 32'h3000_0000, 32'hA5A5_0001}, 0, 0, 32'h0BAD_C0DE);

        // Fixed priority: m1 takes every tie, m0 only once m1 stops asking.
        f_m0_req = 1'b1; f_m1_req = 1'b1;
        grants = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (f_m0_addr_ok || f_m1_addr_ok) begin
                grants++;
                check("fp_tie", {f_m1_addr_ok, f_m0_addr_ok}, 2'b10);
            end
            if (f_m1_data_ok) check("fp_rdata", f_m1_rdata, 32'h5A5A_5A5A);
            tick();
        end
        check("fp_grant_count", grants, 4);
        f_m1_req = 1'b0;
        @(negedge clk);
        check("fp_m0_alone", {f_m1_addr_ok, f_m0_addr_ok}, 2'b01);
        tick();
        f_m0_req = 1'b0;

        // Async reset during ADDR, off the clock edge.
        m0_req = 1'b1; m1_req = 1'b1;
        @(negedge clk);
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        check("pre_reset_s_req", s_req, 1'b1);
        #2 resetn = 1'b0;
        #1 check("reset_async_s_req", s_req, 1'b0);
        tick();
        resetn = 1'b1;
        hv = mk(1, 1, 0, 2'd2, 32'h1FC0_0100, 32'd0, 0, 2'd2, 32'h8000_0800, 32'd0,
                0, 0, 32'h8888_8888, 1'b0);
        capture(hv);
        finish(hv.win, fields_of(hv), hv.adly, hv.ddly, hv.rdata);

        // Async reset during WAIT: the pending response is lost.
        m1_req = 1'b1;
        @(negedge clk);
        tick();
        m1_req = 1'b0;
        s_addr_ok = 1'b1;
        tick();
        s_addr_ok = 1'b0;
        @(negedge clk);
        #2 resetn = 1'b0;
        #1 check("reset_wait_ok", {m1_addr_ok, m0_addr_ok, m1_data_ok, m0_data_ok}, 4'b0000);
        tick();
        resetn = 1'b1;
        s_data_ok = 1'b1;
        @(negedge clk);
        check("reset_lost_resp", {m1_data_ok, m0_data_ok}, 2'b00);
        tick();
        s_data_ok = 1'b0;
        hv = mk(1, 1, 0, 2'd2, 32'h1FC0_0200, 32'd0, 0, 2'd2, 32'h8000_0900, 32'd0,
                0, 1, 32'h9999_9999, 1'b0);
        capture(hv);
        finish(hv.win, fields_of(hv), hv.adly, hv.ddly, hv.rdata);

        @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-requester arbiter that shares one sram-like port between the instruction and data sram-like masters of the CPU memory path, ahead of the AXI bridge. Captures one request at a time, replays it on the shared slave port, and routes the response back to the granted master. Single outstanding transaction, round-robin or fixed data-priority arbitration.

## Interface

Parameters:
- `DATA_PRIO`, default 0: 0 = round-robin between masters; 1 = data master (m1) always wins a tie.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `m0_req` in 1: instruction master request; held until `m0_addr_ok`.
- `m0_wr` in 1: write when 1.
- `m0_size` in 2: 0 = byte, 1 = half, 2 = word.
- `m0_addr` in 32: physical address.
- `m0_wdata` in 32: write data.
- `m0_addr_ok` out 1: request accepted, 1-cycle pulse.
- `m0_data_ok` out 1: response complete, 1-cycle pulse.
- `m0_rdata` out 32: read data, valid with `m0_data_ok`.
- `m1_req`, `m1_wr`, `m1_size`, `m1_addr`, `m1_wdata`, `m1_addr_ok`, `m1_data_ok`, `m1_rdata`: same set for the data master.
- `s_req` out 1: shared-port request.
- `s_wr` out 1, `s_size` out 2, `s_addr` out 32, `s_wdata` out 32: latched request fields.
- `s_addr_ok` in 1: slave accepted address.
- `s_data_ok` in 1: slave response complete.
- `s_rdata` in 32: slave read data.

## Operation

- States: IDLE, ADDR, WAIT.
- IDLE: if any `mX_req`, pick a winner, pulse `mX_addr_ok` combinationally in the same cycle, and latch wr/size/addr/wdata into the request register plus `grant`. Go to ADDR.
- Arbitration: one requester wins. With two requesters and `DATA_PRIO=0`, the master not in `last_grant` wins. With `DATA_PRIO=1`, m1 wins. `last_grant` updates on every capture.
- ADDR: `s_req`=1 with the latched fields held stable. On `s_addr_ok`, go to WAIT.
- WAIT: `s_req`=0. On `s_data_ok`, pulse `data_ok` of the granted master combinationally, with `rdata` = `s_rdata`. Go to IDLE.
- The non-granted master sees `addr_ok`=0 and `data_ok`=0 throughout.
- `s_data_ok` outside WAIT is ignored; no output responds.
- `mX_req` in ADDR or WAIT gets no `addr_ok`. The master keeps holding it and it is arbitrated on the next IDLE.
- `rdata` for a write response is don't-care. `m0_rdata`/`m1_rdata` are driven from `s_rdata` at all times and qualified only by `data_ok`.
- Reset mid-operation: state returns to IDLE immediately and `s_req` drops. Any in-flight slave response is lost. The downstream bridge shares `resetn`.

## Timing

- Reset values: state=IDLE, `last_grant`=1 (so m0 wins the first tie), request register=0, `s_req`=0, all `addr_ok`/`data_ok`=0.
- Cycle 0: `mX_req` in IDLE gives `mX_addr_ok`=1 in the same cycle.
- Cycle 1: `s_req`=1 at the earliest. It stays high until and including the cycle `s_addr_ok`=1.
- `s_data_ok` in WAIT gives `mX_data_ok` in the same cycle. IDLE follows on the next edge.
- Next capture comes the cycle after `data_ok` at the earliest. Minimum transaction is 3 cycles, IDLE, ADDR, WAIT, when `s_addr_ok` and `s_data_ok` each return on first opportunity.
- The slave is expected to give `s_data_ok` no earlier than the cycle after `s_addr_ok`. A same-cycle `s_data_ok` during ADDR is dropped.
- No combinational path runs from `s_*` inputs to `s_*` outputs. Paths from `mX_req` to `mX_addr_ok` and from `s_data_ok` to `mX_data_ok`/`mX_rdata` are permitted.

## Test plan

- Single read:
  - Stimulus: reset, then `m0_req` read at 0x1FC00000. Slave gives `s_addr_ok` on its 1st cycle and `s_data_ok` with 0xDEADBEEF 2 cycles later.
  - Response: `m0_addr_ok` at cycle 0, `s_addr`=0x1FC00000, `s_wr`=0. `m0_data_ok` with `m0_rdata`=0xDEADBEEF. `m1_*` stay 0.
- Tie, round-robin:
  - Stimulus: `DATA_PRIO=0`, both masters request continuously.
  - Response: grants alternate m0, m1, m0, m1. Each grant's `s_addr` matches that master's address.
- Tie, fixed priority:
  - Stimulus: `DATA_PRIO=1`, both masters request.
  - Response: m1 wins every tie. m0 is granted only when `m1_req`=0.
- Write with stalls:
  - Stimulus: m1 writes 0x12345678 to 0x00000010 with size 2. `s_addr_ok` is delayed 5 cycles.
  - Response: `s_req`, `s_wr`=1, `s_wdata` and `s_size` are held stable for all 5 cycles. `m1_data_ok` fires only with `s_data_ok`.
- Spurious response and blocking:
  - Stimulus: `s_data_ok` pulsed in IDLE and in ADDR.
  - Response: no `data_ok` on any master. Also, `m0_req` raised during m1's WAIT gets `m0_addr_ok` only in the cycle after `m1_data_ok`.
- Async reset:
  - Stimulus: `resetn` asserted mid-WAIT, off a clock edge.
  - Response: `s_req`=0 and state=IDLE immediately. After release, m0 wins the first tie.
